controle_pilha: RTL and testbench

Stack controller that sits directly upstream of the `Pilha` stack memory and turns push/pop requests into memory accesses. It owns the stack pointer, drives `Endereco` and `io`, and drives or releases the bidirectional `Data` bus. It returns popped words to the datapath and reports full, empty and error status.

---
 rtl/pilha_pkg.sv | 19 +
 rtl/controle_pilha_if.sv | 24 ++
 rtl/pilha.sv | 30 +++
 rtl/ponteiro_pilha.sv | 35 +++
 rtl/controle_pilha.sv | 122 ++++++++++++
 tb/tb_controle_pilha.sv | 190 +++++++++++++++++++
 6 files changed

// File: rtl/pilha_pkg.sv
// Definitions shared by the stack controller and the Pilha memory:
// FSM states, default geometry and io encoding.
package pilha_pkg;

    typedef enum logic [1:0] {
        OCIOSO,
        ESCRITA,
        LEITURA,
        CAPTURA
    } estado_pilha_t;

    localparam int unsigned LARGURA_PADRAO  = 16;
    localparam int unsigned TAMANHO_PADRAO  = 64;
    localparam int unsigned ENDERECO_PADRAO = 6;

    localparam logic IO_ESCRITA = 1'b1;
    localparam logic IO_LEITURA = 1'b0;

endpackage

// File: rtl/controle_pilha_if.sv
// Datapath-side request/response signals of the stack controller.
interface controle_pilha_if #(
    parameter int unsigned Largura = 16
);
    logic               push;
    logic               pop;
    logic [Largura-1:0] dado_in;
    logic [Largura-1:0] dado_out;
    logic               dado_valido;
    logic               pronto;
    logic               cheia;
    logic               vazia;
    logic               erro;

    modport master (
        output push, pop, dado_in,
        input  dado_out, dado_valido, pronto, cheia, vazia, erro
    );

    modport slave (
        input  push, pop, dado_in,
        output dado_out, dado_valido, pronto, cheia, vazia, erro
    );
endinterface

// File: rtl/pilha.sv
// Single-port stack memory: writes Data when io=1, otherwise registers the
// addressed word and drives it onto Data.
module Pilha
    import pilha_pkg::*;
#(
    parameter int unsigned Largura_da_pilha = LARGURA_PADRAO,
    parameter int unsigned Tamanho_da_pilha = TAMANHO_PADRAO,
    parameter int unsigned Tamanho_endereco = ENDERECO_PADRAO
) (
    input  logic                        clk,
    input  logic [Largura_da_pilha-1:0] Endereco,
    input  logic                        io,
    inout  wire  [Largura_da_pilha-1:0] Data
);
    logic [Largura_da_pilha-1:0] mem [Tamanho_da_pilha];
    logic [Largura_da_pilha-1:0] q;
    logic                        unused_endereco;

    assign unused_endereco = ^Endereco[Largura_da_pilha-1:Tamanho_endereco];

    always_ff @(posedge clk) begin
        if (io == IO_ESCRITA) begin
            mem[Endereco[Tamanho_endereco-1:0]] <= Data;
        end else begin
            q <= mem[Endereco[Tamanho_endereco-1:0]];
        end
    end

    assign Data = (io == IO_LEITURA) ? q : 'z;
endmodule

// File: rtl/ponteiro_pilha.sv
// Stack pointer register (next free slot) with increment/decrement enables
// and full/empty decode from the registered value.
module ponteiro_pilha
    import pilha_pkg::*;
#(
    parameter int unsigned Tamanho_da_pilha = TAMANHO_PADRAO,
    parameter int unsigned Tamanho_endereco = ENDERECO_PADRAO
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      inc,
    input  logic                      dec,
    output logic [Tamanho_endereco:0] sp,
    output logic                      cheia,
    output logic                      vazia
);
    localparam logic [Tamanho_endereco:0] Um     = 1;
    localparam logic [Tamanho_endereco:0] Maximo = Tamanho_da_pilha[Tamanho_endereco:0];

    logic [Tamanho_endereco:0] sp_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q <= '0;
        end else if (inc) begin
            sp_q <= sp_q + Um;
        end else if (dec) begin
            sp_q <= sp_q - Um;
        end
    end

    assign sp    = sp_q;
    assign cheia = (sp_q == Maximo);
    assign vazia = (sp_q == '0);
endmodule

// File: rtl/controle_pilha.sv
// Stack controller: turns push/pop requests into Pilha accesses, owns the
// stack pointer and the controller side of the shared data bus.
module controle_pilha
    import pilha_pkg::*;
#(
    parameter int unsigned Largura_da_pilha = LARGURA_PADRAO,
    parameter int unsigned Tamanho_da_pilha = TAMANHO_PADRAO,
    parameter int unsigned Tamanho_endereco = ENDERECO_PADRAO
) (
    input  logic                        clk,
    input  logic                        rst,
    controle_pilha_if.slave             bus,
    output logic [Largura_da_pilha-1:0] mem_endereco,
    output logic                        mem_io,
    inout  wire  [Largura_da_pilha-1:0] mem_data
);
    localparam logic [Tamanho_endereco:0] Um = 1;

    estado_pilha_t               estado_q, estado_d;
    logic                        io_q;
    logic [Largura_da_pilha-1:0] dado_q;
    logic [Largura_da_pilha-1:0] dado_out_q;
    logic                        dado_valido_q;
    logic                        erro_q, erro_d;
    logic                        latch, captura, inc, dec;
    logic [Tamanho_endereco:0]   sp, endereco;
    logic                        cheia, vazia;

    ponteiro_pilha #(
        .Tamanho_da_pilha (Tamanho_da_pilha),
        .Tamanho_endereco (Tamanho_endereco)
    ) u_ponteiro (
        .clk   (clk),
        .rst   (rst),
        .inc   (inc),
        .dec   (dec),
        .sp    (sp),
        .cheia (cheia),
        .vazia (vazia)
    );

    always_comb begin
        estado_d = estado_q;
        erro_d   = 1'b0;
        latch    = 1'b0;
        captura  = 1'b0;
        inc      = 1'b0;
        dec      = 1'b0;
        unique case (estado_q)
            OCIOSO: begin
                if (bus.push && bus.pop) begin
                    erro_d = 1'b1;
                end else if (bus.push) begin
                    if (cheia) begin
                        erro_d = 1'b1;
                    end else begin
                        latch    = 1'b1;
                        estado_d = ESCRITA;
                    end
                end else if (bus.pop) begin
                    if (vazia) begin
                        erro_d = 1'b1;
                    end else begin
                        estado_d = LEITURA;
                    end
                end
            end
            ESCRITA: begin
                inc      = 1'b1;
                estado_d = OCIOSO;
            end
            LEITURA: estado_d = CAPTURA;
            CAPTURA: begin
                captura  = 1'b1;
                dec      = 1'b1;
                estado_d = OCIOSO;
            end
            default: estado_d = OCIOSO;
        endcase
    end

    // io_q is both mem_io and the bus driver enable, so they can never disagree.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q      <= OCIOSO;
            io_q          <= IO_LEITURA;
            dado_q        <= '0;
            dado_out_q    <= '0;
            dado_valido_q <= 1'b0;
            erro_q        <= 1'b0;
        end else begin
            estado_q      <= estado_d;
            io_q          <= (estado_d == ESCRITA) ? IO_ESCRITA : IO_LEITURA;
            dado_valido_q <= captura;
            erro_q        <= erro_d;
            if (latch) begin
                dado_q <= bus.dado_in;
            end
            if (captura) begin
                dado_out_q <= mem_data;
            end
        end
    end

    always_comb begin
        endereco = sp;
        if (estado_q == LEITURA || estado_q == CAPTURA) begin
            endereco = sp - Um;
        end
    end

    assign mem_endereco    = Largura_da_pilha'(endereco);
    assign mem_io          = io_q;
    assign mem_data        = (io_q == IO_ESCRITA) ? dado_q : 'z;

    assign bus.pronto      = (estado_q == OCIOSO);
    assign bus.cheia       = cheia;
    assign bus.vazia       = vazia;
    assign bus.erro        = erro_q;
    assign bus.dado_out    = dado_out_q;
    assign bus.dado_valido = dado_valido_q;
endmodule

// File: tb/tb_controle_pilha.sv
// Directed bench for controle_pilha + Pilha with a reference stack model and
// a queue of expected popped words.
module tb_controle_pilha;
    logic        clk;
    logic        rst;
    wire  [15:0] mem_data;
    logic [15:0] mem_endereco;
    logic        mem_io;

    controle_pilha_if #(.Largura(16)) bus ();

    controle_pilha #(
        .Largura_da_pilha (16),
        .Tamanho_da_pilha (64),
        .Tamanho_endereco (6)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .mem_endereco (mem_endereco),
        .mem_io       (mem_io),
        .mem_data     (mem_data)
    );

    Pilha #(
        .Largura_da_pilha (16),
        .Tamanho_da_pilha (64),
        .Tamanho_endereco (6)
    ) u_pilha (
        .clk      (clk),
        .Endereco (mem_endereco),
        .io       (mem_io),
        .Data     (mem_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [15:0] modelo[$];
    logic [15:0] esperado[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ocioso(input string tag);
        chk({tag, "_pronto"}, 32'(bus.pronto), 32'd1);
        chk({tag, "_io"}, 32'(mem_io), 32'd0);
        chk({tag, "_sp"}, 32'(mem_endereco), 32'(modelo.size()));
        chk({tag, "_vazia"}, 32'(bus.vazia), 32'(modelo.size() == 0));
        chk({tag, "_cheia"}, 32'(bus.cheia), 32'(modelo.size() == 64));
    endtask

    task automatic do_push(input logic [15:0] v);
        int unsigned sp_antes;
        sp_antes    = modelo.size();
        bus.push    = 1'b1;
        bus.dado_in = v;
        tick();
        bus.push    = 1'b0;
        bus.dado_in = 16'hxxxx;
        chk("escrita_pronto", 32'(bus.pronto), 32'd0);
        chk("escrita_io", 32'(mem_io), 32'd1);
        chk("escrita_end", 32'(mem_endereco), 32'(sp_antes));
        chk("escrita_bus", 32'(mem_data), 32'(v));
        tick();
        modelo.push_back(v);
        chk_ocioso("apos_push");
    endtask

    task automatic do_pop();
        int unsigned n;
        logic [15:0] exp;
        esperado.push_back(modelo[$]);
        bus.pop = 1'b1;
        tick();
        bus.pop = 1'b0;
        chk("leitura_pronto", 32'(bus.pronto), 32'd0);
        chk("leitura_io", 32'(mem_io), 32'd0);
        chk("leitura_end", 32'(mem_endereco), 32'(modelo.size() - 1));
        tick();
        chk("captura_io", 32'(mem_io), 32'd0);
        chk("captura_bus", 32'(mem_data), 32'(esperado[$]));
        tick();
        n = 0;
        while (bus.dado_valido !== 1'b1 && n < 4) begin
            tick();
            n++;
        end
        chk("valido_latencia", 32'(n), 32'd0);
        exp = esperado.pop_front();
        void'(modelo.pop_back());
        chk("dado_out", 32'(bus.dado_out), 32'(exp));
        chk_ocioso("apos_pop");
        tick();
        chk("valido_pulso", 32'(bus.dado_valido), 32'd0);
    endtask

    task automatic do_ilegal(input logic p, input logic q, input string tag);
        bus.push = p;
        bus.pop  = q;
        tick();
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        chk({tag, "_erro"}, 32'(bus.erro), 32'd1);
        chk({tag, "_valido"}, 32'(bus.dado_valido), 32'd0);
        chk_ocioso(tag);
        tick();
        chk({tag, "_erro_pulso"}, 32'(bus.erro), 32'd0);
        chk_ocioso({tag, "_depois"});
    endtask

    initial begin
        rst         = 1'b1;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.dado_in = '0;
        tick();
        tick();
        chk("rst_dado_out", 32'(bus.dado_out), 32'd0);
        chk("rst_valido", 32'(bus.dado_valido), 32'd0);
        chk("rst_erro", 32'(bus.erro), 32'd0);
        chk_ocioso("rst");
        rst = 1'b0;
        tick();

        // Basic LIFO order
        do_push(16'h1234);
        do_push(16'hBEEF);
        do_pop();
        do_pop();
        chk("lifo_vazia", 32'(bus.vazia), 32'd1);

        // Underflow
        do_ilegal(1'b0, 1'b1, "pop_vazia");

        // Fill, overflow, drain
        for (int i = 0; i < 64; i++) do_push(16'(i));
        chk("cheia_64", 32'(bus.cheia), 32'd1);
        do_ilegal(1'b1, 1'b0, "push_cheia");
        for (int i = 0; i < 64; i++) do_pop();
        chk("drenada_vazia", 32'(bus.vazia), 32'd1);

        // Simultaneous push and pop with 3 words held
        do_push(16'h0A01);
        do_push(16'h0A02);
        do_push(16'h0A03);
        do_ilegal(1'b1, 1'b1, "push_pop");
        do_pop();
        do_pop();
        do_pop();

        // Reset during CAPTURA
        do_push(16'h0055);
        bus.pop = 1'b1;
        tick();
        bus.pop = 1'b0;
        tick();
        chk("pre_rst_captura_io", 32'(mem_io), 32'd0);
        rst = 1'b1;
        #1;
        modelo.delete();
        esperado.delete();
        chk("rst_async_dado_out", 32'(bus.dado_out), 32'd0);
        chk("rst_async_valido", 32'(bus.dado_valido), 32'd0);
        chk("rst_async_erro", 32'(bus.erro), 32'd0);
        chk_ocioso("rst_async");
        tick();
        rst = 1'b0;
        tick();
        chk("pos_rst_valido", 32'(bus.dado_valido), 32'd0);
        do_push(16'h00AA);
        do_pop();
        chk("pos_rst_dado", 32'(bus.dado_out), 32'h00AA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
